// File: rtl/viterbi_tag_reorder.sv
// rtl/viterbi_tag_reorder.sv - reorders backtrace POS tags into sentence order; optional stats counters under TAG_REORDER_STATS_EN
module viterbi_tag_reorder #(
    parameter int word_num     = 16,
    parameter int word_num_bit = 4,
    parameter int POS_num      = 11,
    parameter int POS_num_bit  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tag_valid,
    input  logic [word_num_bit-1:0] tag_key,
    input  logic [POS_num_bit-1:0]  tag_pos,
    input  logic                    tag_last,
    input  logic                    tag_error,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [word_num_bit-1:0] out_key,
    output logic [POS_num_bit-1:0]  out_pos,
    output logic                    out_last,
    output logic                    seq_err,
    output logic [7:0]              sent_cnt,
    output logic [7:0]              err_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // One extra bit so the legal-tag limit can be compared without truncation.
    localparam logic [POS_num_bit:0] pos_limit = POS_num[POS_num_bit:0];

    state_t                  state, state_next;
    logic [POS_num_bit-1:0]  mem [word_num];
    logic [word_num-1:0]     filled, filled_next, filled_upd, need_mask;
    logic [word_num_bit-1:0] max_key, max_next, max_upd;
    logic [word_num_bit-1:0] rd_ptr, rd_next;
    logic                    bad, bad_next, bad_upd;
    logic                    complete, mem_we, seq_err_next;

    // Sentence view as it would look after absorbing the current tag.
    always_comb begin
        filled_upd = filled | (word_num'(1) << tag_key);
        max_upd    = (tag_key > max_key) ? tag_key : max_key;
        bad_upd    = bad | filled[tag_key] | ({1'b0, tag_pos} >= pos_limit);
        need_mask  = '0;
        for (int i = 0; i < word_num; i++) begin
            need_mask[i] = (i <= int'(max_upd));
        end
        complete   = &(filled_upd | ~need_mask);
    end

    // Next-state logic: collect tags, judge the sentence on tag_last, drain in key order.
    always_comb begin
        state_next   = state;
        filled_next  = filled;
        max_next     = max_key;
        bad_next     = bad;
        rd_next      = rd_ptr;
        mem_we       = 1'b0;
        seq_err_next = 1'b0;
        case (state)
            COLLECT: begin
                if (tag_valid) begin
                    if (tag_error) begin
                        filled_next  = '0;
                        max_next     = '0;
                        bad_next     = 1'b0;
                        seq_err_next = 1'b1;
                    end else begin
                        mem_we      = 1'b1;
                        filled_next = filled_upd;
                        max_next    = max_upd;
                        bad_next    = bad_upd;
                        if (tag_last) begin
                            if (bad_upd || !complete) begin
                                filled_next  = '0;
                                max_next     = '0;
                                bad_next     = 1'b0;
                                seq_err_next = 1'b1;
                            end else begin
                                state_next = DRAIN;
                                rd_next    = '0;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                // Tags arriving while draining cannot be stored without corrupting the output.
                if (tag_valid) begin
                    seq_err_next = 1'b1;
                end
                if (out_ready) begin
                    if (rd_ptr == max_key) begin
                        filled_next = '0;
                        max_next    = '0;
                        bad_next    = 1'b0;
                        rd_next     = '0;
                        state_next  = COLLECT;
                    end else begin
                        rd_next = rd_ptr + 1'b1;
                    end
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Control and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= COLLECT;
            filled  <= '0;
            max_key <= '0;
            bad     <= 1'b0;
            rd_ptr  <= '0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_next;
            filled  <= filled_next;
            max_key <= max_next;
            bad     <= bad_next;
            rd_ptr  <= rd_next;
            seq_err <= seq_err_next;
        end
    end

    // Tag storage; contents are only meaningful where filled is set, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[tag_key] <= tag_pos;
        end
    end

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == DRAIN);
    assign out_key   = rd_ptr;
    assign out_pos   = out_valid ? mem[rd_ptr] : '0;
    assign out_last  = out_valid && (rd_ptr == max_key);

`ifdef TAG_REORDER_STATS_EN
    logic [7:0] sent_q, err_q;

    // Free-running wrap-around statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent_q <= '0;
            err_q  <= '0;
        end else begin
            if (out_valid && out_ready && out_last) begin
                sent_q <= sent_q + 8'd1;
            end
            if (seq_err_next) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign sent_cnt = sent_q;
    assign err_cnt  = err_q;
`else
    assign sent_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_viterbi_tag_reorder.sv
// tb/tb_viterbi_tag_reorder.sv - scoreboard bench for viterbi_tag_reorder
module tb_viterbi_tag_reorder;

    localparam int PN = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic       tag_valid, tag_last, tag_error;
    logic [3:0] tag_key, tag_pos;
    logic       in_ready, out_valid, out_ready, out_last, seq_err;
    logic [3:0] out_key, out_pos;
    logic [7:0] sent_cnt, err_cnt;

    always #5 clk = ~clk;

    viterbi_tag_reorder dut (
        .clk       (clk),
        .reset     (reset),
        .tag_valid (tag_valid),
        .tag_key   (tag_key),
        .tag_pos   (tag_pos),
        .tag_last  (tag_last),
        .tag_error (tag_error),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_pos   (out_pos),
        .out_last  (out_last),
        .seq_err   (seq_err),
        .sent_cnt  (sent_cnt),
        .err_cnt   (err_cnt)
    );

    typedef struct packed {
        logic [3:0] key;
        logic [3:0] pos;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_err = 0;
    int    obs_err = 0;
    int    exp_sent = 0;
    int    ready_mode = 1;

    // Reference sentence state: key -> tag, plus a sticky "bad" flag.
    int    m_tags[int];
    bit    m_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] exp_sent_cnt();
`ifdef TAG_REORDER_STATS_EN
        return 8'(exp_sent);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [7:0] exp_err_cnt();
`ifdef TAG_REORDER_STATS_EN
        return 8'(exp_err);
`else
        return 8'd0;
`endif
    endfunction

    // Reference: apply one accepted tag to the sentence and predict the outcome.
    task automatic model_tag(input int key, input int pos, input bit last, input bit err);
        int  maxk;
        bit  ok;
        if (err) begin
            m_tags.delete();
            m_bad = 0;
            exp_err++;
        end else begin
            if (m_tags.exists(key) || pos >= PN) m_bad = 1;
            m_tags[key] = pos;
            if (last) begin
                maxk = 0;
                foreach (m_tags[k]) if (k > maxk) maxk = k;
                ok = !m_bad;
                for (int k = 0; k <= maxk; k++) if (!m_tags.exists(k)) ok = 0;
                if (ok) begin
                    for (int k = 0; k <= maxk; k++)
                        exp_q.push_back('{key: 4'(k), pos: 4'(m_tags[k]), last: (k == maxk)});
                    exp_sent++;
                end else begin
                    exp_err++;
                end
                m_tags.delete();
                m_bad = 0;
            end
        end
    endtask

    // Present one tag once the block is collecting; returns #1 after the accepting edge.
    task automatic send_tag(input int key, input int pos, input bit last, input bit err);
        int n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        tag_valid = 1'b1;
        tag_key   = 4'(key);
        tag_pos   = 4'(pos);
        tag_last  = last;
        tag_error = err;
        @(posedge clk); #1;
        tag_valid = 1'b0;
        tag_last  = 1'b0;
        tag_error = 1'b0;
        model_tag(key, pos, last, err);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && in_ready) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", (exp_q.size() == 0 && in_ready), 1);
    endtask

    // out_ready driver: 0 = low, 1 = high, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pop expectations on each handshake, count error pulses, check stall stability.
    bit          hold_pend = 0;
    logic [12:0] hold_val;
    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            hold_pend = 0;
        end else begin
            if (seq_err) obs_err++;
            if (hold_pend) check("hold_stable", {3'b0, out_valid, out_key, out_pos, out_last}, {3'b0, hold_val});
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_valid, out_key, out_pos, out_last};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", exp_q.size(), 1);
                end else begin
                    b = exp_q.pop_front();
                    check("beat", {out_key, out_pos, out_last}, {b.key, b.pos, b.last});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int keys[$];
        int n, kind, j, tmp, pos, errpos;

        reset     = 1'b1;
        tag_valid = 1'b0;
        tag_key   = '0;
        tag_pos   = '0;
        tag_last  = 1'b0;
        tag_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_key", out_key, 0);
        check("rst_out_pos", out_pos, 0);
        check("rst_out_last", out_last, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_sent_cnt", sent_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic reorder: first beat the cycle after tag_last, three-cycle drain.
        send_tag(2, 5, 0, 0);
        send_tag(1, 3, 0, 0);
        send_tag(0, 7, 1, 0);
        check("basic_first_valid", {out_valid, out_key, out_pos}, {1'b1, 4'd0, 4'd7});
        repeat (3) @(posedge clk);
        #1;
        check("basic_in_ready_back", in_ready, 1);
        check("basic_sent_cnt", sent_cnt, exp_sent_cnt());

        // Backpressure after the first beat.
        send_tag(2, 5, 0, 0);
        send_tag(1, 3, 0, 0);
        send_tag(0, 7, 1, 0);
        @(posedge clk); #1;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_held_beat", {out_valid, out_key, out_pos}, {1'b1, 4'd1, 4'd3});
        ready_mode = 1;
        wait_idle();

        // Missing word.
        send_tag(2, 4, 0, 0);
        send_tag(0, 1, 1, 0);
        check("miss_seq_err", {seq_err, out_valid, in_ready}, {1'b1, 1'b0, 1'b1});
        @(posedge clk); #1;
        check("miss_seq_err_drop", {seq_err, out_valid, in_ready}, {1'b0, 1'b0, 1'b1});
        check("miss_err_cnt", err_cnt, exp_err_cnt());

        // Illegal tag value.
        send_tag(1, 12, 0, 0);
        send_tag(0, 2, 1, 0);
        check("illegal_seq_err", seq_err, 1);
        // Duplicate key.
        send_tag(1, 2, 0, 0);
        send_tag(1, 3, 0, 0);
        send_tag(0, 2, 1, 0);
        check("dup_seq_err", seq_err, 1);
        // Error tag, then a clean sentence.
        send_tag(1, 6, 0, 0);
        send_tag(4, 2, 0, 1);
        check("tag_error_seq_err", seq_err, 1);
        send_tag(1, 9, 0, 0);
        send_tag(0, 10, 1, 0);
        wait_idle();

        // Drop during a 16-word drain.
        for (int k = 15; k >= 0; k--) send_tag(k, $urandom_range(0, PN - 1), (k == 0), 0);
        tag_valid = 1'b1;
        tag_key   = 4'd3;
        tag_pos   = 4'd1;
        tag_last  = 1'b1;
        @(posedge clk); #1;
        tag_valid = 1'b0;
        tag_last  = 1'b0;
        exp_err++;
        check("drain_drop_seq_err", seq_err, 1);
        wait_idle();

        // Randomized sentences under random backpressure.
        ready_mode = 2;
        for (int s = 0; s < 40; s++) begin
            n    = $urandom_range(1, 16);
            kind = $urandom_range(0, 9);
            keys.delete();
            for (int k = 0; k < n; k++) keys.push_back(k);
            for (int k = n - 1; k > 0; k--) begin
                j = $urandom_range(0, k);
                tmp = keys[k]; keys[k] = keys[j]; keys[j] = tmp;
            end
            if (kind == 0 && n > 2) keys.delete($urandom_range(0, n - 2));
            if (kind == 2) keys.insert($urandom_range(0, keys.size() - 1), keys[$urandom_range(0, keys.size() - 1)]);
            errpos = (kind == 3) ? $urandom_range(0, keys.size() - 1) : -1;
            for (int i = 0; i < keys.size(); i++) begin
                pos = (kind == 1 && i == keys.size() / 2) ? $urandom_range(11, 15) : $urandom_range(0, PN - 1);
                send_tag(keys[i], pos, (i == keys.size() - 1), (i == errpos));
            end
        end
        ready_mode = 1;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_seq_err_pulses", obs_err, exp_err);
        check("final_err_cnt", err_cnt, exp_err_cnt());
        check("final_sent_cnt", sent_cnt, exp_sent_cnt());

        // Reset in the middle of a drain.
        send_tag(2, 1, 0, 0);
        send_tag(1, 2, 0, 0);
        send_tag(0, 3, 1, 0);
        @(posedge clk); #1;
        check("pre_reset_beat1", {out_valid, out_key}, {1'b1, 4'd1});
        reset = 1'b1;
        #1;
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_in_ready", in_ready, 1);
        check("mid_reset_counters", {sent_cnt, err_cnt}, 16'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("post_reset_idle", {out_valid, in_ready}, {1'b0, 1'b1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
